// File: rtl/control_unit_mc_v2_if.sv
// Control bundle between the multicycle control unit and its datapath.
//   master : control unit side (drives mem_req and every datapath control)
//   slave  : datapath/memory side (drives instruction and mem_ready)
// Signals:
//   instruction  IR contents            mem_ready    access completes this cycle
//   mem_req      memory request         PC*/ALU*/Load*/WriteReg/MemToReg/...
//   EPCWrite/CauseWrite/cause  exception capture   halted/state  status, debug
interface control_unit_mc_v2_if;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        mem_req;
  logic        PCWrite;
  logic        PCWriteCond;
  logic [1:0]  PCSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUFunct;
  logic        LoadIR;
  logic        LoadRegA;
  logic        LoadRegB;
  logic        LoadALUOut;
  logic        LoadMDR;
  logic        WriteReg;
  logic [2:0]  MemToReg;
  logic        DMemWrite;
  logic [1:0]  tam;
  logic [1:0]  BranchOp;
  logic [1:0]  ShiftControl;
  logic        EPCWrite;
  logic        CauseWrite;
  logic [1:0]  cause;
  logic        halted;
  logic [4:0]  state;

  modport master (
    input  instruction, mem_ready,
    output mem_req, PCWrite, PCWriteCond, PCSrc, ALUSrcA, ALUSrcB, ALUFunct,
           LoadIR, LoadRegA, LoadRegB, LoadALUOut, LoadMDR, WriteReg, MemToReg,
           DMemWrite, tam, BranchOp, ShiftControl, EPCWrite, CauseWrite, cause,
           halted, state
  );

  modport slave (
    output instruction, mem_ready,
    input  mem_req, PCWrite, PCWriteCond, PCSrc, ALUSrcA, ALUSrcB, ALUFunct,
           LoadIR, LoadRegA, LoadRegB, LoadALUOut, LoadMDR, WriteReg, MemToReg,
           DMemWrite, tam, BranchOp, ShiftControl, EPCWrite, CauseWrite, cause,
           halted, state
  );
endinterface

// File: rtl/control_unit_mc_v2.sv
// Multicycle RISC-V control FSM with variable-latency memory handshake,
// bus timeout, precise exceptions and a sticky halt state.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    control_unit_mc_v2_if.master: instruction/mem_ready in, full
//          datapath control bundle, exception capture and status out
// Outputs are decoded from the current state (memory states also look at
// mem_ready), so reset forces every output to 0 immediately.
//
// state    | code | meaning
// RST      |  0   | reset, all outputs idle
// FETCH    |  1   | instruction fetch, PC <= PC+4 on completion
// DECODE   |  2   | read A/B, ALUOut <= PC+offset, dispatch
// ADD/SUB/AND | 3/4/5 | R-type ALU op into ALUOut
// SLT      |  6   | set-less-than, register operand, write back
// ADDR     |  7   | rs1+imm (addi / load-store address)
// SHIFT    |  8   | shifter write back
// SLTI     |  9   | set-less-than, immediate operand, write back
// LUI      | 10   | immediate write back
// BR       | 11   | conditional branch
// LINK     | 12   | rd <= PC (jal/jalr)
// MEM_RD   | 13   | data read, wait for mem_ready
// MEM_WR   | 14   | data write, wait for mem_ready
// WB_ALU   | 15   | rd <= ALUOut
// WB_MEM   | 16   | rd <= MDR
// JALR_A   | 17   | ALUOut <= rs1+imm
// JUMP     | 18   | PC <= ALUOut
// EXC      | 19   | capture EPC/cause, PC <= vector
// HALT     | 20   | stopped until reset
module control_unit_mc_v2 #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int TIMEOUT_W      = 4,
  parameter bit EXC_ENABLE     = 1'b1
) (
  input logic clk,
  input logic rst_n,
  control_unit_mc_v2_if.master bus
);

  typedef enum logic [4:0] {
    S_RST = 5'd0, S_FETCH = 5'd1, S_DECODE = 5'd2, S_ADD = 5'd3, S_SUB = 5'd4,
    S_AND = 5'd5, S_SLT = 5'd6, S_ADDR = 5'd7, S_SHIFT = 5'd8, S_SLTI = 5'd9,
    S_LUI = 5'd10, S_BR = 5'd11, S_LINK = 5'd12, S_MEM_RD = 5'd13,
    S_MEM_WR = 5'd14, S_WB_ALU = 5'd15, S_WB_MEM = 5'd16, S_JALR_A = 5'd17,
    S_JUMP = 5'd18, S_EXC = 5'd19, S_HALT = 5'd20
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam state_t S_TRAP = EXC_ENABLE ? S_EXC : S_HALT;

  state_t               st, st_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic [1:0]           cause_q, cause_nxt;
  logic                 mem_state, mem_wait, timeout;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] imm_hi;

  assign opcode = bus.instruction[6:0];
  assign f3     = bus.instruction[14:12];
  assign f7     = bus.instruction[31:25];
  assign imm_hi = bus.instruction[31:26];

  assign mem_state = (st == S_FETCH) || (st == S_MEM_RD) || (st == S_MEM_WR);
  assign mem_wait  = mem_state && !bus.mem_ready;
  // The counter holds the number of waits already seen, so the wait cycle
  // that finds it at TIMEOUT_CYCLES-1 is the last one tolerated.
  assign timeout   = mem_wait && (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_RST;
      wait_cnt <= '0;
      cause_q  <= 2'd0;
    end else begin
      st      <= st_nxt;
      cause_q <= cause_nxt;
      if (st_nxt != st)
        wait_cnt <= '0;
      else if (mem_wait)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    st_nxt           = st;
    cause_nxt        = cause_q;
    bus.mem_req      = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.PCSrc        = 2'b00;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.ALUFunct     = 3'b000;
    bus.LoadIR       = 1'b0;
    bus.LoadRegA     = 1'b0;
    bus.LoadRegB     = 1'b0;
    bus.LoadALUOut   = 1'b0;
    bus.LoadMDR      = 1'b0;
    bus.WriteReg     = 1'b0;
    bus.MemToReg     = 3'd0;
    bus.DMemWrite    = 1'b0;
    bus.tam          = 2'b00;
    bus.BranchOp     = 2'b00;
    bus.ShiftControl = 2'b00;
    bus.EPCWrite     = 1'b0;
    bus.CauseWrite   = 1'b0;
    bus.cause        = 2'd0;
    bus.halted       = 1'b0;

    case (st)
      S_RST: st_nxt = S_FETCH;

      S_FETCH: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.LoadIR   = 1'b1;
          bus.PCWrite  = 1'b1;
          bus.ALUSrcB  = 2'b01;
          bus.ALUFunct = 3'b001;
          st_nxt       = S_DECODE;
        end else if (timeout) begin
          st_nxt    = S_TRAP;
          cause_nxt = 2'd1;
        end
      end

      S_DECODE: begin
        bus.LoadRegA   = 1'b1;
        bus.LoadRegB   = 1'b1;
        bus.LoadALUOut = 1'b1;
        bus.ALUSrcB    = 2'b11;
        bus.ALUFunct   = 3'b001;
        st_nxt         = S_TRAP;
        cause_nxt      = 2'd0;
        case (opcode)
          7'b0110011: begin
            if (f7 == 7'b0000000) begin
              case (f3)
                3'b000:  st_nxt = S_ADD;
                3'b111:  st_nxt = S_AND;
                3'b010:  st_nxt = S_SLT;
                default: st_nxt = S_TRAP;
              endcase
            end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
              st_nxt = S_SUB;
            end
          end
          7'b0010011: begin
            case (f3)
              3'b000: st_nxt = S_ADDR;
              3'b001: st_nxt = S_SHIFT;
              3'b101: if (imm_hi == 6'b000000 || imm_hi == 6'b010000) st_nxt = S_SHIFT;
              3'b010: st_nxt = S_SLTI;
              default: st_nxt = S_TRAP;
            endcase
          end
          7'b0000011: st_nxt = S_ADDR;
          7'b0100011: begin
            if (f3 == 3'b111 || f3 == 3'b010 || f3 == 3'b001 || f3 == 3'b000)
              st_nxt = S_ADDR;
          end
          7'b0110111: st_nxt = S_LUI;
          7'b1100011: st_nxt = S_BR;
          7'b1100111: begin
            case (f3)
              3'b001, 3'b101, 3'b100: st_nxt = S_BR;
              3'b000:                 st_nxt = S_LINK;
              default:                st_nxt = S_TRAP;
            endcase
          end
          7'b1101111: st_nxt = S_LINK;
          7'b1110011: st_nxt = S_HALT;
          default:    st_nxt = S_TRAP;
        endcase
      end

      S_ADD, S_SUB, S_AND: begin
        bus.ALUSrcA    = 1'b1;
        bus.LoadALUOut = 1'b1;
        bus.ALUFunct   = (st == S_ADD) ? 3'b001 : (st == S_SUB) ? 3'b010 : 3'b011;
        st_nxt         = S_WB_ALU;
      end

      S_ADDR: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUFunct   = 3'b001;
        bus.LoadALUOut = 1'b1;
        case (opcode)
          7'b0000011: st_nxt = S_MEM_RD;
          7'b0100011: st_nxt = S_MEM_WR;
          default:    st_nxt = S_WB_ALU;
        endcase
      end

      S_MEM_RD: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ready) begin
          bus.LoadMDR = 1'b1;
          st_nxt      = S_WB_MEM;
        end else if (timeout) begin
          st_nxt    = S_TRAP;
          cause_nxt = 2'd1;
        end
      end

      S_MEM_WR: begin
        bus.mem_req = 1'b1;
        case (f3)
          3'b000:  bus.tam = 2'b11;
          3'b001:  bus.tam = 2'b10;
          3'b010:  bus.tam = 2'b01;
          default: bus.tam = 2'b00;
        endcase
        if (bus.mem_ready) begin
          bus.DMemWrite = 1'b1;
          st_nxt        = S_FETCH;
        end else if (timeout) begin
          st_nxt    = S_TRAP;
          cause_nxt = 2'd1;
        end else begin
          bus.DMemWrite = 1'b1;
        end
      end

      S_WB_ALU: begin
        bus.WriteReg = 1'b1;
        st_nxt       = S_FETCH;
      end

      S_WB_MEM: begin
        bus.WriteReg = 1'b1;
        bus.MemToReg = 3'd1;
        st_nxt       = S_FETCH;
      end

      S_LUI: begin
        bus.WriteReg = 1'b1;
        bus.MemToReg = 3'd2;
        st_nxt       = S_FETCH;
      end

      S_SHIFT: begin
        bus.WriteReg     = 1'b1;
        bus.MemToReg     = 3'd4;
        bus.ShiftControl = (f3 == 3'b001) ? 2'b00 : (imm_hi[4] ? 2'b10 : 2'b01);
        st_nxt           = S_FETCH;
      end

      S_SLT, S_SLTI: begin
        bus.ALUSrcA  = 1'b1;
        bus.ALUSrcB  = (st == S_SLTI) ? 2'b10 : 2'b00;
        bus.ALUFunct = 3'b010;
        bus.WriteReg = 1'b1;
        bus.MemToReg = 3'd5;
        st_nxt       = S_FETCH;
      end

      S_BR: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUFunct    = 3'b010;
        bus.PCWriteCond = 1'b1;
        bus.PCSrc       = 2'b01;
        if (opcode == 7'b1100111) begin
          case (f3)
            3'b001:  bus.BranchOp = 2'b01;
            3'b101:  bus.BranchOp = 2'b10;
            default: bus.BranchOp = 2'b11;
          endcase
        end
        st_nxt = S_FETCH;
      end

      S_LINK: begin
        bus.WriteReg = 1'b1;
        bus.MemToReg = 3'd3;
        st_nxt       = (opcode == 7'b1100111) ? S_JALR_A : S_JUMP;
      end

      S_JALR_A: begin
        bus.ALUSrcA    = 1'b1;
        bus.ALUSrcB    = 2'b10;
        bus.ALUFunct   = 3'b001;
        bus.LoadALUOut = 1'b1;
        st_nxt         = S_JUMP;
      end

      S_JUMP: begin
        bus.PCWrite = 1'b1;
        bus.PCSrc   = 2'b01;
        st_nxt      = S_FETCH;
      end

      S_EXC: begin
        bus.EPCWrite   = 1'b1;
        bus.CauseWrite = 1'b1;
        bus.cause      = cause_q;
        bus.PCWrite    = 1'b1;
        bus.PCSrc      = 2'b10;
        st_nxt         = S_FETCH;
      end

      S_HALT: bus.halted = 1'b1;

      default: st_nxt = S_RST;
    endcase
  end

  assign bus.state = st;

endmodule
